// File: rtl/pipeline_pkg.sv
// Shared pipeline types and constants for the fetch/decode boundary.
package pipeline_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR    = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] instr;
  } ifid_t;

  function automatic ifid_t ifid_load(input logic [XLEN-1:0] pc, input logic [XLEN-1:0] instr);
    ifid_t b;
    b.valid    = 1'b1;
    b.pc       = pc;
    b.pc_plus4 = pc + 32'd4;
    b.instr    = instr;
    return b;
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: control from EX/ID, instruction-memory port and IF/ID bundle.
interface fetch_stage_if;
  import pipeline_pkg::*;

  logic            stall;
  logic            redirect;
  logic [XLEN-1:0] redirect_pc;
  logic            imem_en;
  logic [XLEN-1:0] imem_addr;
  logic [XLEN-1:0] imem_rdata;
  logic            id_valid;
  logic [XLEN-1:0] id_pc;
  logic [XLEN-1:0] id_pc_plus4;
  logic [XLEN-1:0] id_instr;

  modport master (
    input  stall, redirect, redirect_pc, imem_rdata,
    output imem_en, imem_addr, id_valid, id_pc, id_pc_plus4, id_instr
  );

  modport slave (
    output stall, redirect, redirect_pc, imem_rdata,
    input  imem_en, imem_addr, id_valid, id_pc, id_pc_plus4, id_instr
  );
endinterface

// File: rtl/fetch_skid_buf.sv
// Single-entry hold register for a fetch response that arrives while ID is stalled.
module fetch_skid_buf
  import pipeline_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            capture,
  input  logic            drain,
  input  logic            clear,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_instr,
  output logic            valid,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] instr
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= 1'b0;
      pc    <= '0;
      instr <= '0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (capture) begin
      valid <= 1'b1;
      pc    <= in_pc;
      instr <= in_instr;
    end else if (drain) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, issues to a 1-cycle synchronous imem, and
// produces the registered IF/ID bundle with stall and redirect handling.
module fetch_stage #(
  parameter logic [pipeline_pkg::XLEN-1:0] RESET_PC  = pipeline_pkg::RESET_VECTOR,
  parameter logic [pipeline_pkg::XLEN-1:0] NOP_INSTR = pipeline_pkg::NOP_INSTR
) (
  input  logic                 clk,
  input  logic                 rst,
  fetch_stage_if.master        fs
);
  import pipeline_pkg::*;

  logic [XLEN-1:0] pc_reg;
  logic [XLEN-1:0] req_pc;
  logic            req_valid;
  ifid_t           ifid;

  logic            issue;
  logic            skid_capture;
  logic            skid_drain;
  logic            skid_valid;
  logic [XLEN-1:0] skid_pc;
  logic [XLEN-1:0] skid_instr;

  assign issue        = rst & ~fs.stall & ~fs.redirect;
  assign skid_capture = fs.stall & ~fs.redirect & req_valid;
  assign skid_drain   = ~fs.stall & ~fs.redirect;

  assign fs.imem_en     = issue;
  assign fs.imem_addr   = pc_reg;
  assign fs.id_valid    = ifid.valid;
  assign fs.id_pc       = ifid.pc;
  assign fs.id_pc_plus4 = ifid.pc_plus4;
  assign fs.id_instr    = ifid.instr;

  fetch_skid_buf u_skid (
    .clk      (clk),
    .rst      (rst),
    .capture  (skid_capture),
    .drain    (skid_drain),
    .clear    (fs.redirect),
    .in_pc    (req_pc),
    .in_instr (fs.imem_rdata),
    .valid    (skid_valid),
    .pc       (skid_pc),
    .instr    (skid_instr)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_reg        <= RESET_PC;
      req_valid     <= 1'b0;
      req_pc        <= '0;
      ifid.valid    <= 1'b0;
      ifid.pc       <= '0;
      ifid.pc_plus4 <= '0;
      ifid.instr    <= NOP_INSTR;
    end else begin
      req_valid <= issue;
      if (fs.redirect) begin
        pc_reg     <= fs.redirect_pc;
        ifid.valid <= 1'b0;
        ifid.instr <= NOP_INSTR;
      end else if (!fs.stall) begin
        pc_reg <= pc_reg + 32'd4;
        req_pc <= pc_reg;
        // A held skid entry is older than the response now on imem_rdata.
        if (skid_valid) begin
          ifid <= ifid_load(skid_pc, skid_instr);
        end else if (req_valid) begin
          ifid <= ifid_load(req_pc, fs.imem_rdata);
        end else begin
          ifid.valid <= 1'b0;
          ifid.instr <= NOP_INSTR;
        end
      end
    end
  end

endmodule
